ntt_coeff_unloader: RTL and testbench

Streams a polynomial of `N_COEFF` coefficients out of the NTT coefficient memory after the transform finishes. It is the read-side counterpart of the memory load port. It takes over memory port 0 with `mem_sel`, issues sequential reads, and absorbs the 1-cycle memory read latency with a 2-entry buffer. Words leave on a valid/ready stream, with `out_last` on the final coefficient.

---
 rtl/ntt_coeff_unloader.sv | 162 ++++++++++++++++
 tb/tb_ntt_coeff_unloader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_unloader.sv
// ntt_coeff_unloader: streams N_COEFF coefficients out of the NTT coefficient memory.
// The unloader takes over memory port 0 (mem_sel) and issues sequential reads.
// A 2-entry buffer absorbs the 1-cycle memory read latency, and words leave on a
// valid/ready stream with out_last on the final coefficient.
// Optional feature: define UNLOAD_CANON_EN to reduce each output word modulo
// q = 8380417 with one compare-subtract at the buffer output.
module ntt_coeff_unloader #(
    parameter int N_COEFF = 256,
    parameter int AW      = 16,
    parameter int DW      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          mem_sel,
    output logic [AW-1:0] mem_A,
    output logic          mem_WEB,
    input  logic [DW-1:0] mem_Q,
    output logic          mem_ren,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [22:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int            CW       = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_COEFF - 1);
    localparam logic [22:0]   Q_MOD    = 23'd8380417;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] tx_cnt;
    logic [AW-1:0] addr_q;
    logic          inflight;
    logic [1:0]    occ;
    logic [1:0]    credit;
    logic [22:0]   fifo_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [22:0]   head;
    logic          pop;
    logic          finish;
    logic          unused_q_bits;

    // Bit 23 of the memory word is not part of the coefficient.
    assign unused_q_bits = ^mem_Q[DW-1:23];

    assign mem_WEB   = 1'b1;
    assign mem_A     = addr_q;
    assign busy      = (state != IDLE);
    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid && (tx_cnt == LAST_IDX);
    assign pop       = out_valid && out_ready;
    assign finish    = (state == DRAIN) && pop && out_last;
    assign credit    = occ + {1'b0, inflight};
    assign head      = fifo_q[rd_ptr];

`ifdef UNLOAD_CANON_EN
    assign out_data = (head >= Q_MOD) ? (head - Q_MOD) : head;
`else
    assign out_data = head;
`endif

    // State register for the unload sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read issue; a pop this cycle frees a slot in time for a new read.
    always_comb begin
        state_next = state;
        mem_ren    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if ((credit - {1'b0, pop}) < 2'd2) begin
                    mem_ren = 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address, issue/transfer counters, port ownership and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            mem_sel  <= 1'b0;
            done     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            done     <= finish;
            inflight <= mem_ren;
            if ((state == IDLE) && start) begin
                addr_q  <= base_addr;
                rd_cnt  <= '0;
                tx_cnt  <= '0;
                mem_sel <= 1'b1;
            end else begin
                if (mem_ren) begin
                    addr_q <= addr_q + AW'(1);
                    rd_cnt <= rd_cnt + CW'(1);
                end
                if (pop) begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
                if (finish) begin
                    mem_sel <= 1'b0;
                end
            end
        end
    end

    // Two-entry buffer catching read data one cycle after each issued read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_q[wr_ptr] <= mem_Q[22:0];
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ntt_coeff_unloader.sv
// tb_ntt_coeff_unloader: directed bench for ntt_coeff_unloader with a synchronous
// 1-cycle-latency memory model. Honours UNLOAD_CANON_EN when it is defined.
module tb_ntt_coeff_unloader;

    localparam int N  = 256;
    localparam int AW = 16;
    localparam int DW = 24;
    localparam int MAX_CYC = 3000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mem_sel;
    logic [AW-1:0] mem_A;
    logic          mem_WEB;
    logic [DW-1:0] mem_Q;
    logic          mem_ren;
    logic          out_valid;
    logic          out_ready;
    logic [22:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks;
    int failures;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] mem_q_reg;

    logic [22:0]   got_data [$];
    logic          got_last [$];
    int            got_cyc [$];
    logic [AW-1:0] addr_log [$];
    int            done_cyc;
    int            first_ren_cyc;
    int            cap_viol;
    int            stab_viol;
    logic          timed_out;
    logic          sel_at_done;
    logic          done_after;
    logic          busy_after;

    ntt_coeff_unloader #(.N_COEFF(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .mem_sel   (mem_sel),
        .mem_A     (mem_A),
        .mem_WEB   (mem_WEB),
        .mem_Q     (mem_Q),
        .mem_ren   (mem_ren),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data for an address appears one cycle after the read.
    always @(posedge clk) begin
        if (mem_ren) mem_q_reg <= mem[mem_A];
    end
    assign mem_Q = mem_q_reg;

    // Starts one unload and records everything the stream and memory port do.
    task automatic run_stream(input logic [AW-1:0] base, input int ready_pct, input int stop_after,
                              input int pulse_cyc, input logic [AW-1:0] pulse_base);
        int   outstanding;
        logic prev_hold;
        logic [22:0] prev_data;
        logic prev_last;
        logic seen_done;
        got_data.delete(); got_last.delete(); got_cyc.delete(); addr_log.delete();
        done_cyc = -1; first_ren_cyc = -1; cap_viol = 0; stab_viol = 0; timed_out = 1'b0;
        sel_at_done = 1'bx; done_after = 1'bx; busy_after = 1'bx;
        outstanding = 0; prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0; seen_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        for (int c = 0; c <= MAX_CYC; c++) begin
            if (c == MAX_CYC) begin
                timed_out = 1'b1;
                break;
            end
            out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
            start     = (c == pulse_cyc);
            base_addr = (c == pulse_cyc) ? pulse_base : '0;
            @(negedge clk);
            if (seen_done) begin
                done_after = done; busy_after = busy;
                break;
            end
            if (mem_ren) begin
                addr_log.push_back(mem_A);
                if (first_ren_cyc < 0) first_ren_cyc = c;
                if ((outstanding - ((out_valid && out_ready) ? 1 : 0)) >= 2) cap_viol++;
            end
            if (prev_hold && ((out_data !== prev_data) || (out_last !== prev_last))) stab_viol++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_last.push_back(out_last); got_cyc.push_back(c);
                outstanding--;
            end
            if (mem_ren) outstanding++;
            if (done === 1'b1) begin
                done_cyc = c; seen_done = 1'b1; sel_at_done = mem_sel;
            end
            if ((stop_after > 0) && (got_data.size() == stop_after)) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        base_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_sel got=%b exp=0", mem_sel); end
        checks++; if (mem_A !== 16'h0) begin failures++; $display("[TB] FAIL reset_mem_A got=%h exp=0", mem_A); end
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_ren got=%b exp=0", mem_ren); end
        checks++; if (mem_WEB !== 1'b1) begin failures++; $display("[TB] FAIL reset_mem_WEB got=%b exp=1", mem_WEB); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 23'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_unload();
        run_stream(16'h0000, 100, 0, -1, 16'h0000);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout got=%b exp=0", timed_out); end
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=%0d", got_data.size(), N); end
        checks++; if (first_ren_cyc != 0) begin failures++; $display("[TB] FAIL basic_first_read_cycle got=%0d exp=0", first_ren_cyc); end
        checks++; if (addr_log[0] !== 16'h0000) begin failures++; $display("[TB] FAIL basic_first_addr got=%h exp=0000", addr_log[0]); end
        for (int k = 0; k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== 23'(3 * k)) begin failures++; $display("[TB] FAIL basic_word[%0d] got=%0d exp=%0d", k, got_data[k], 3 * k); end
            checks++; if (got_last[k] !== (k == N - 1)) begin failures++; $display("[TB] FAIL basic_last[%0d] got=%b exp=%b", k, got_last[k], (k == N - 1)); end
            checks++; if (got_cyc[k] != k + 2) begin failures++; $display("[TB] FAIL basic_cycle[%0d] got=%0d exp=%0d", k, got_cyc[k], k + 2); end
        end
        checks++; if (done_cyc != N + 2) begin failures++; $display("[TB] FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, N + 2); end
        checks++; if (sel_at_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_mem_sel_at_done got=%b exp=0", sel_at_done); end
        checks++; if (done_after !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse_width got=%b exp=0", done_after); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b exp=0", busy_after); end
        checks++; if (cap_viol != 0) begin failures++; $display("[TB] FAIL basic_buffer_capacity got=%0d exp=0", cap_viol); end
        checks++; if (mem_WEB !== 1'b1) begin failures++; $display("[TB] FAIL basic_mem_WEB got=%b exp=1", mem_WEB); end
    endtask

    task automatic test_backpressure();
        run_stream(16'h0000, 50, 0, -1, 16'h0000);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL bp_timeout got=%b exp=0", timed_out); end
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== 23'(3 * k)) begin failures++; $display("[TB] FAIL bp_word[%0d] got=%0d exp=%0d", k, got_data[k], 3 * k); end
            checks++; if (got_last[k] !== (k == N - 1)) begin failures++; $display("[TB] FAIL bp_last[%0d] got=%b exp=%b", k, got_last[k], (k == N - 1)); end
        end
        checks++; if (cap_viol != 0) begin failures++; $display("[TB] FAIL bp_buffer_capacity got=%0d exp=0", cap_viol); end
        checks++; if (stab_viol != 0) begin failures++; $display("[TB] FAIL bp_stability got=%0d exp=0", stab_viol); end
        checks++; if (sel_at_done !== 1'b0) begin failures++; $display("[TB] FAIL bp_mem_sel_at_done got=%b exp=0", sel_at_done); end
    endtask

    task automatic test_addr_wrap();
        logic [22:0] e;
        mem[16'hFFFE] = 24'h00ABCD;
        mem[16'hFFFF] = 24'h812345;
        run_stream(16'hFFFE, 100, 0, -1, 16'h0000);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL wrap_timeout got=%b exp=0", timed_out); end
        checks++; if (addr_log[0] !== 16'hFFFE) begin failures++; $display("[TB] FAIL wrap_addr0 got=%h exp=FFFE", addr_log[0]); end
        checks++; if (addr_log[1] !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_addr1 got=%h exp=FFFF", addr_log[1]); end
        checks++; if (addr_log[2] !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_addr2 got=%h exp=0000", addr_log[2]); end
        checks++; if (addr_log[3] !== 16'h0001) begin failures++; $display("[TB] FAIL wrap_addr3 got=%h exp=0001", addr_log[3]); end
        checks++; if (addr_log.size() != N) begin failures++; $display("[TB] FAIL wrap_read_count got=%0d exp=%0d", addr_log.size(), N); end
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            if (k == 0) e = 23'h00ABCD;
            else if (k == 1) e = 23'h012345;
            else e = 23'(3 * (k - 2));
            checks++; if (got_data[k] !== e) begin failures++; $display("[TB] FAIL wrap_word[%0d] got=%h exp=%h", k, got_data[k], e); end
        end
    endtask

    task automatic test_start_while_busy();
        run_stream(16'h0000, 100, 0, 50, 16'h4000);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_timeout got=%b exp=0", timed_out); end
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL busy_start_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== 23'(3 * k)) begin failures++; $display("[TB] FAIL busy_start_word[%0d] got=%0d exp=%0d", k, got_data[k], 3 * k); end
        end
        for (int k = 0; k < addr_log.size(); k++) begin
            checks++; if (addr_log[k] !== 16'(k)) begin failures++; $display("[TB] FAIL busy_start_addr[%0d] got=%h exp=%h", k, addr_log[k], 16'(k)); end
        end
        checks++; if (done_cyc != N + 2) begin failures++; $display("[TB] FAIL busy_start_done_cycle got=%0d exp=%0d", done_cyc, N + 2); end
    endtask

    task automatic test_reset_mid();
        run_stream(16'h0000, 100, 100, -1, 16'h0000);
        checks++; if (got_data.size() != 100) begin failures++; $display("[TB] FAIL rstmid_pre_count got=%0d exp=100", got_data.size()); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (mem_sel !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_mem_sel got=%b exp=0", mem_sel); end
        checks++; if (mem_A !== 16'h0) begin failures++; $display("[TB] FAIL rstmid_mem_A got=%h exp=0", mem_A); end
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_mem_ren got=%b exp=0", mem_ren); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 23'h0) begin failures++; $display("[TB] FAIL rstmid_out_data got=%h exp=0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0", done); end
        @(posedge clk); #2;
        rst = 1'b0;
        run_stream(16'h0000, 100, 0, -1, 16'h0000);
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL rstmid_replay_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
            checks++; if (got_data[k] !== 23'(3 * k)) begin failures++; $display("[TB] FAIL rstmid_replay_word[%0d] got=%0d exp=%0d", k, got_data[k], 3 * k); end
        end
        checks++; if (done_cyc != N + 2) begin failures++; $display("[TB] FAIL rstmid_replay_done_cycle got=%0d exp=%0d", done_cyc, N + 2); end
    endtask

    task automatic test_canon();
        logic [22:0] e;
        mem[16'h2000] = 24'd8380417;
        mem[16'h2001] = 24'd8380420;
        mem[16'h2002] = 24'd8380416;
        mem[16'h2003] = 24'h800005;
        run_stream(16'h2000, 100, 0, -1, 16'h0000);
        checks++; if (got_data.size() != N) begin failures++; $display("[TB] FAIL canon_count got=%0d exp=%0d", got_data.size(), N); end
        for (int k = 0; k < got_data.size(); k++) begin
`ifdef UNLOAD_CANON_EN
            if (k == 0) e = 23'd0;
            else if (k == 1) e = 23'd3;
            else if (k == 2) e = 23'd8380416;
            else if (k == 3) e = 23'd5;
            else e = 23'd0;
`else
            if (k == 0) e = 23'd8380417;
            else if (k == 1) e = 23'd8380420;
            else if (k == 2) e = 23'd8380416;
            else if (k == 3) e = 23'd5;
            else e = 23'd0;
`endif
            checks++; if (got_data[k] !== e) begin failures++; $display("[TB] FAIL canon_word[%0d] got=%0d exp=%0d", k, got_data[k], e); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        for (int k = 0; k < N; k++) mem[k] = 24'(3 * k);
        test_reset();
        test_basic_unload();
        test_backpressure();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid();
        test_canon();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
